// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and helpers for the sequential ALU.
// Used by seq_alu and alu_iter_muldiv.
package alu_pkg;

  localparam logic [3:0] OP_PASS_A = 4'b0001;
  localparam logic [3:0] OP_PASS_B = 4'b0010;
  localparam logic [3:0] OP_INC1   = 4'b0011;
  localparam logic [3:0] OP_INC2   = 4'b0100;
  localparam logic [3:0] OP_INC3   = 4'b0101;
  localparam logic [3:0] OP_DEC1   = 4'b0110;
  localparam logic [3:0] OP_DEC2   = 4'b0111;
  localparam logic [3:0] OP_DEC3   = 4'b1000;
  localparam logic [3:0] OP_ADD    = 4'b1001;
  localparam logic [3:0] OP_SUB    = 4'b1010;
  localparam logic [3:0] OP_MUL    = 4'b1011;
  localparam logic [3:0] OP_DIV    = 4'b1100;
  localparam logic [3:0] OP_CONCAT = 4'b1101;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DIV} state_t;

  typedef enum logic {MODE_MUL, MODE_DIV} muldiv_mode_t;

  // 0000, 1110 and 1111 are accepted but leave c and dz untouched.
  function automatic logic is_valid_op(input logic [3:0] op);
    return (op >= OP_PASS_A) && (op <= OP_CONCAT);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// With SEQ_ALU_HWMUL_EN defined only the divide path is built.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_W      = 18,
  parameter int ITER_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  muldiv_mode_t      mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done_i,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

  // x: multiplicand / divisor, y: multiplier / quotient shift, acc: product / remainder
  logic              active_q;
  muldiv_mode_t      mode_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] x_q, y_q, acc_q;

  logic [DATA_W:0]   rem_sh, rem_diff;
  logic              rem_ge;
  logic [DATA_W-1:0] rem_nxt, quo_nxt;
  logic [DATA_W-1:0] x_nxt, y_nxt, acc_nxt;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the if-branches can leave one unassigned and infer a latch.
  always_comb begin
    rem_sh   = {acc_q, y_q[DATA_W-1]};
    rem_ge   = (rem_sh >= {1'b0, x_q});
    rem_diff = rem_sh - {1'b0, x_q};
    rem_nxt  = rem_ge ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_nxt  = {y_q[DATA_W-2:0], rem_ge};

    x_nxt   = x_q;
    y_nxt   = quo_nxt;
    acc_nxt = rem_nxt;
    result  = quo_nxt;
`ifndef SEQ_ALU_HWMUL_EN
    if (mode_q == MODE_MUL) begin
      acc_nxt = y_q[0] ? (acc_q + x_q) : acc_q;
      x_nxt   = x_q << 1;
      y_nxt   = y_q >> 1;
      result  = acc_nxt;
    end
`else
    if (mode_q != MODE_DIV) result = '0;
`endif
  end

  // result is the value the final step produces, so the top can capture it
  // on the same edge that retires the operation.
  assign done_i = active_q && (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values. The datapath registers are reset too, so a
  // reset mid-operation leaves no partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      mode_q   <= MODE_MUL;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
    end else if (go) begin
      active_q <= 1'b1;
      mode_q   <= mode;
      cnt_q    <= '0;
      x_q      <= (mode == MODE_DIV) ? a : b;
      y_q      <= (mode == MODE_DIV) ? b : a;
      acc_q    <= '0;
    end else if (active_q) begin
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      acc_q <= acc_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: start/done protocol, result register and flags.
// Define SEQ_ALU_HWMUL_EN to replace the iterative multiply with a 1-cycle one.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] c,
  output logic              lsb,
  output logic              neg,
  output logic              zero,
  output logic              dz
);

  localparam int MUL_CYCLES = DATA_W;
  localparam int HALF_W     = DATA_W / 2;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] exec_res;

  logic              iter_go;
  muldiv_mode_t      iter_mode;
  logic              iter_done;
  logic [DATA_W-1:0] iter_result;

  alu_iter_muldiv #(
    .DATA_W      (DATA_W),
    .ITER_CYCLES (MUL_CYCLES)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (iter_go),
    .mode   (iter_mode),
    .a      (a),
    .b      (b),
    .done_i (iter_done),
    .result (iter_result)
  );

  // Single-cycle results come straight from the operand inputs and are
  // registered on the accepting edge, so c is valid in the EXEC (done) cycle.
  always_comb begin
    exec_res = c_q;
    case (alu_sel)
      OP_PASS_A: exec_res = a;
      OP_PASS_B: exec_res = b;
      OP_INC1:   exec_res = b + DATA_W'(1);
      OP_INC2:   exec_res = b + DATA_W'(2);
      OP_INC3:   exec_res = b + DATA_W'(3);
      OP_DEC1:   exec_res = b - DATA_W'(1);
      OP_DEC2:   exec_res = b - DATA_W'(2);
      OP_DEC3:   exec_res = b - DATA_W'(3);
      OP_ADD:    exec_res = b + a;
      OP_SUB:    exec_res = b - a;
`ifdef SEQ_ALU_HWMUL_EN
      OP_MUL:    exec_res = b * a;
`endif
      OP_CONCAT: exec_res = {a[HALF_W-1:0], b[HALF_W-1:0]};
      default:   exec_res = c_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    dz_d      = dz_q;
    iter_go   = 1'b0;
    iter_mode = MODE_DIV;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXEC;
          if (alu_sel == OP_DIV) begin
            if (a == '0) begin
              c_d  = '1;
              dz_d = 1'b1;
            end else begin
              iter_go   = 1'b1;
              iter_mode = MODE_DIV;
              dz_d      = 1'b0;
              state_d   = DIV;
            end
          end
`ifndef SEQ_ALU_HWMUL_EN
          else if (alu_sel == OP_MUL) begin
            iter_go   = 1'b1;
            iter_mode = MODE_MUL;
            dz_d      = 1'b0;
            state_d   = MUL;
          end
`endif
          else if (is_valid_op(alu_sel)) begin
            c_d  = exec_res;
            dz_d = 1'b0;
          end
        end
      end
      // EXEC is the done cycle for every op; start is ignored here.
      EXEC: state_d = IDLE;
      MUL, DIV: begin
        if (iter_done) begin
          c_d     = iter_result;
          state_d = EXEC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q == MUL) || (state_q == DIV);
  assign done = (state_q == EXEC);
  assign c    = c_q;
  assign dz   = dz_q;
  assign lsb  = c_q[0];
  assign neg  = c_q[DATA_W-1];
  assign zero = (c_q == '0);

endmodule
